fp_wb_arbiter: RTL and testbench
================================

FP_WB_ARBITER -- requirements
Module: fp_wb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_UNITS, default 4, the number of writeback-producing FP units (range 2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 34, the result width (flopoco single-precision format, 2 exception bits plus 32).
REQ-003 The block SHALL have parameter ID_WIDTH, default 3, the instruction id width.
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port unit_done  input  NUM_UNITS  per-unit result valid; bit i belongs to unit i.
REQ-007 The block SHALL have port unit_rd  input  NUM_UNITS*DATA_WIDTH  per-unit result; slice i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port unit_id  input  NUM_UNITS*ID_WIDTH  per-unit instruction id; slice i at [i*ID_WIDTH +: ID_WIDTH].
REQ-009 The block SHALL have port unit_ack  output  NUM_UNITS  per-unit accept; combinational, one-hot or zero.
REQ-010 The block SHALL have port wb_valid  output  1  registered result valid toward the FP register file.
REQ-011 The block SHALL have port wb_data  output  DATA_WIDTH  registered result.
REQ-012 The block SHALL have port wb_id  output  ID_WIDTH  registered id of wb_data.
REQ-013 The block SHALL have port wb_ready  input  1  downstream accepts wb_data when wb_valid and wb_ready are both 1.
REQ-014 The block SHALL have port wb_grant_idx  output  clog2(NUM_UNITS)  registered index of the unit whose result is in wb_data.

Function
REQ-015 Producer contract: once unit_done[i]=1, unit i holds done, rd, id stable until the cycle unit_ack[i]=1; the block SHALL rely only on this.
REQ-016 load SHALL equal !wb_valid || wb_ready; no capture occurs when load=0.
REQ-017 Grant: among units with unit_done=1, the block SHALL pick the first one at or after priority pointer ptr, searching upward mod NUM_UNITS.
REQ-018 unit_ack[i] SHALL be 1 exactly when load=1, unit i is picked, and unit_done[i]=1; otherwise 0.
REQ-019 unit_ack SHALL never be asserted for a unit with unit_done=0, and at most one bit SHALL be 1 per cycle.
REQ-020 On a cycle with an ack to unit i: wb_valid<=1, wb_data<=unit_rd slice i, wb_id<=unit_id slice i, wb_grant_idx<=i, ptr<=(i+1) mod NUM_UNITS.
REQ-021 On load=1 with no unit_done: wb_valid<=0; wb_data, wb_id, wb_grant_idx, ptr hold.
REQ-022 On load=0 (wb_valid=1, wb_ready=0): all registers SHALL hold and unit_ack SHALL be 0.
REQ-023 Latency: an acked result SHALL appear on wb_valid/wb_data the next cycle; throughput one result per cycle while wb_ready=1.
REQ-024 Fairness: a unit holding unit_done=1 SHALL be acked within NUM_UNITS consecutive load cycles.
REQ-025 Data and id SHALL pass unmodified; no arithmetic on payload.

Reset
REQ-026 While rst=0: wb_valid=0, wb_data=0, wb_id=0, wb_grant_idx=0, ptr=0, and unit_ack SHALL be forced to 0 regardless of other inputs.
REQ-027 Reset asserted mid-transfer SHALL drop the held result without ack; after rst rises, the first ack occurs no earlier than the first clk edge with rst=1.

Verification
REQ-028 Single: unit_done=0b0100, unit 2 rd=0x0_3F800000, id=5, wb_ready=1 -> unit_ack=0b0100 that cycle; next cycle wb_valid=1, wb_data=0x0_3F800000, wb_id=5, wb_grant_idx=2.
REQ-029 Round-robin: after reset, unit_done=0b1111 held (each unit deasserts after its ack), wb_ready=1 -> acks 0b0001,0b0010,0b0100,0b1000 on four consecutive cycles.
REQ-030 Backpressure: wb_valid=1, wb_ready=0 for 3 cycles with unit_done=0b0011 -> unit_ack=0 and wb_data stable all 3 cycles; first cycle wb_ready=1 -> exactly one ack.
REQ-031 Pointer wrap: ptr=3 (last grant unit 2), unit_done=0b1001 -> ack unit 3; next cycle with unit_done=0b0001 -> ack unit 0, ptr=1.
REQ-032 Reset mid-operation: wb_valid=1, rst pulsed low between edges -> wb_valid=0 immediately, unit_ack=0 while low, ptr=0 after release.
REQ-033 Idle drain: wb_valid=1, wb_ready=1, unit_done=0 -> next cycle wb_valid=0, wb_data unchanged.

Source files
------------

// File: rtl/fp_wb_arbiter_if.sv
// Bundle between the FP execution units, the writeback arbiter and the FP register file.
// The arbiter side uses the slave modport; the producer/consumer side uses master.
interface fp_wb_arbiter_if #(
    parameter int NUM_UNITS  = 4,
    parameter int DATA_WIDTH = 34,
    parameter int ID_WIDTH   = 3
);
    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [NUM_UNITS-1:0]            unit_done;
    logic [NUM_UNITS*DATA_WIDTH-1:0] unit_rd;
    logic [NUM_UNITS*ID_WIDTH-1:0]   unit_id;
    logic [NUM_UNITS-1:0]            unit_ack;
    logic                            wb_valid;
    logic [DATA_WIDTH-1:0]           wb_data;
    logic [ID_WIDTH-1:0]             wb_id;
    logic                            wb_ready;
    logic [IDX_W-1:0]                wb_grant_idx;

    modport slave (
        input  unit_done, unit_rd, unit_id, wb_ready,
        output unit_ack, wb_valid, wb_data, wb_id, wb_grant_idx
    );

    modport master (
        output unit_done, unit_rd, unit_id, wb_ready,
        input  unit_ack, wb_valid, wb_data, wb_id, wb_grant_idx
    );
endinterface

// File: rtl/fp_wb_arbiter.sv
// Round-robin writeback arbiter: picks one finished FP unit per load cycle and
// registers its result, id and unit index toward the FP register file.
module fp_wb_arbiter #(
    parameter int NUM_UNITS  = 4,
    parameter int DATA_WIDTH = 34,
    parameter int ID_WIDTH   = 3
) (
    input  logic           clk,
    input  logic           rst,
    fp_wb_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);
    localparam logic [IDX_W:0]   NUM_EXT  = (IDX_W + 1)'(NUM_UNITS);

    logic                  r_wb_valid;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic [ID_WIDTH-1:0]   r_wb_id;
    logic [IDX_W-1:0]      r_grant_idx;
    logic [IDX_W-1:0]      r_ptr;

    logic                  w_load;
    logic                  w_found;
    logic                  w_hit;
    logic [IDX_W:0]        w_cand;
    logic [IDX_W-1:0]      w_pick;
    logic [IDX_W-1:0]      w_ptr_next;
    logic [DATA_WIDTH-1:0] w_data;
    logic [ID_WIDTH-1:0]   w_id;
    logic [NUM_UNITS-1:0]  w_ack;

    assign w_load     = !r_wb_valid || bus.wb_ready;
    assign w_ptr_next = (w_pick == LAST_IDX) ? '0 : w_pick + IDX_W'(1);

    // Search upward from the priority pointer, wrapping at NUM_UNITS, for the first done unit.
    always_comb begin
        w_found = 1'b0;
        w_hit   = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W + 1)'(k);
            if (w_cand >= NUM_EXT) begin
                w_cand = w_cand - NUM_EXT;
            end else begin
                w_cand = w_cand;
            end
            w_hit   = !w_found && bus.unit_done[w_cand[IDX_W-1:0]];
            w_pick  = w_hit ? w_cand[IDX_W-1:0] : w_pick;
            w_found = w_found || w_hit;
        end
    end

    // Payload mux selecting the picked unit's result and id slices.
    always_comb begin
        w_data = '0;
        w_id   = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_data = (w_pick == IDX_W'(i)) ? bus.unit_rd[i*DATA_WIDTH +: DATA_WIDTH] : w_data;
            w_id   = (w_pick == IDX_W'(i)) ? bus.unit_id[i*ID_WIDTH +: ID_WIDTH]     : w_id;
        end
    end

    // One-hot accept; reset gates it so no unit is released while the arbiter is held in reset.
    always_comb begin
        w_ack = '0;
        if (rst && w_load && w_found) begin
            w_ack[w_pick] = 1'b1;
        end else begin
            w_ack = '0;
        end
    end

    // Output register and priority pointer; a load with nothing done only drops valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid  <= 1'b0;
            r_wb_data   <= '0;
            r_wb_id     <= '0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            if (w_found) begin
                r_wb_valid  <= 1'b1;
                r_wb_data   <= w_data;
                r_wb_id     <= w_id;
                r_grant_idx <= w_pick;
                r_ptr       <= w_ptr_next;
            end else begin
                r_wb_valid  <= 1'b0;
            end
        end else begin
            r_wb_valid  <= r_wb_valid;
        end
    end

    assign bus.unit_ack     = w_ack;
    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_data      = r_wb_data;
    assign bus.wb_id        = r_wb_id;
    assign bus.wb_grant_idx = r_grant_idx;
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Bench for fp_wb_arbiter: directed scenarios followed by randomized traffic
// checked against a cycle-level reference of the grant/writeback rules.
module tb_fp_wb_arbiter;
    localparam int N  = 4;
    localparam int DW = 34;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fp_wb_arbiter_if #(.NUM_UNITS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    fp_wb_arbiter #(.NUM_UNITS(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_unit(input int i, input logic [DW-1:0] d, input logic [IW-1:0] id);
        bus.unit_rd[i*DW +: DW] = d;
        bus.unit_id[i*IW +: IW] = id;
    endtask

    function automatic int ref_pick(input logic [N-1:0] d, input int p);
        for (int k = 0; k < N; k++) begin
            if (d[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        bus.unit_done = 4'b1111;
        bus.unit_rd   = '1;
        bus.unit_id   = '1;
        bus.wb_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.unit_ack !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", bus.unit_ack); end
        total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.wb_valid); end
        total++; if (bus.wb_data !== 34'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.wb_data); end
        total++; if (bus.wb_id !== 3'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", bus.wb_id); end
        total++; if (bus.wb_grant_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", bus.wb_grant_idx); end
        @(negedge clk);
        bus.unit_done = 4'b0000;
        rst = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        set_unit(2, 34'h0_3F800000, 3'd5);
        bus.unit_done = 4'b0100;
        bus.wb_ready  = 1'b1;
        #1;
        total++; if (bus.unit_ack !== 4'b0100) begin bad++; $display("FAIL single_ack got=%b want=0100", bus.unit_ack); end
        cyc();
        bus.unit_done = 4'b0000;
        total++; if (bus.wb_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", bus.wb_valid); end
        total++; if (bus.wb_data !== 34'h0_3F800000) begin bad++; $display("FAIL single_data got=%h want=03f800000", bus.wb_data); end
        total++; if (bus.wb_id !== 3'd5) begin bad++; $display("FAIL single_id got=%0d want=5", bus.wb_id); end
        total++; if (bus.wb_grant_idx !== 2'd2) begin bad++; $display("FAIL single_idx got=%0d want=2", bus.wb_grant_idx); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        for (int k = 0; k < N; k++) set_unit(k, 34'h1000 + DW'(k), IW'(k + 1));
        bus.unit_done = 4'b1111;
        for (int k = 0; k < N; k++) begin
            #1;
            want = N'(1) << k;
            total++; if (bus.unit_ack !== want) begin bad++; $display("FAIL rr_ack%0d got=%b want=%b", k, bus.unit_ack, want); end
            cyc();
            bus.unit_done[k] = 1'b0;
            total++; if (bus.wb_data !== 34'h1000 + DW'(k)) begin bad++; $display("FAIL rr_data%0d got=%h want=%h", k, bus.wb_data, 34'h1000 + DW'(k)); end
            total++; if (bus.wb_grant_idx !== 2'(k)) begin bad++; $display("FAIL rr_idx%0d got=%0d want=%0d", k, bus.wb_grant_idx, k); end
        end
    endtask

    task automatic test_backpressure();
        set_unit(0, 34'h2_AAAA0000, 3'd1);
        set_unit(1, 34'h1_BBBB0000, 3'd2);
        bus.unit_done = 4'b0011;
        bus.wb_ready  = 1'b1;
        #1;
        total++; if (bus.unit_ack !== 4'b0001) begin bad++; $display("FAIL bp_first_ack got=%b want=0001", bus.unit_ack); end
        cyc();
        set_unit(0, 34'h3_CCCC0000, 3'd3);
        bus.wb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (bus.unit_ack !== 4'b0000) begin bad++; $display("FAIL bp_stall_ack%0d got=%b want=0000", c, bus.unit_ack); end
            total++; if (bus.wb_data !== 34'h2_AAAA0000 || bus.wb_valid !== 1'b1) begin bad++; $display("FAIL bp_stall_data%0d got=%h/%b want=2aaaa0000/1", c, bus.wb_data, bus.wb_valid); end
            cyc();
        end
        bus.wb_ready = 1'b1;
        #1;
        total++; if (bus.unit_ack !== 4'b0010) begin bad++; $display("FAIL bp_release_ack got=%b want=0010", bus.unit_ack); end
        cyc();
        bus.unit_done = 4'b0001;
        total++; if (bus.wb_data !== 34'h1_BBBB0000) begin bad++; $display("FAIL bp_release_data got=%h want=1bbbb0000", bus.wb_data); end
        #1;
        total++; if (bus.unit_ack !== 4'b0001) begin bad++; $display("FAIL bp_second_ack got=%b want=0001", bus.unit_ack); end
        cyc();
        bus.unit_done = 4'b0000;
        total++; if (bus.wb_data !== 34'h3_CCCC0000 || bus.wb_id !== 3'd3) begin bad++; $display("FAIL bp_second_data got=%h/%0d want=3cccc0000/3", bus.wb_data, bus.wb_id); end
    endtask

    task automatic test_ptr_wrap();
        bus.unit_done = 4'b0100;
        #1;
        cyc();
        total++; if (bus.wb_grant_idx !== 2'd2) begin bad++; $display("FAIL wrap_setup_idx got=%0d want=2", bus.wb_grant_idx); end
        bus.unit_done = 4'b1001;
        #1;
        total++; if (bus.unit_ack !== 4'b1000) begin bad++; $display("FAIL wrap_ack3 got=%b want=1000", bus.unit_ack); end
        cyc();
        bus.unit_done = 4'b0001;
        #1;
        total++; if (bus.unit_ack !== 4'b0001) begin bad++; $display("FAIL wrap_ack0 got=%b want=0001", bus.unit_ack); end
        cyc();
        total++; if (bus.wb_grant_idx !== 2'd0) begin bad++; $display("FAIL wrap_idx0 got=%0d want=0", bus.wb_grant_idx); end
        // Pointer now at 1: unit 1 must win over unit 0.
        bus.unit_done = 4'b0011;
        #1;
        total++; if (bus.unit_ack !== 4'b0010) begin bad++; $display("FAIL wrap_ptr1 got=%b want=0010", bus.unit_ack); end
        cyc();
        bus.unit_done = 4'b0000;
    endtask

    task automatic test_reset_mid();
        set_unit(0, 34'h0_DDDD0000, 3'd4);
        bus.unit_done = 4'b0001;
        bus.wb_ready  = 1'b1;
        #1;
        cyc();
        bus.wb_ready = 1'b0;
        set_unit(1, 34'h1_EEEE0000, 3'd6);
        bus.unit_done = 4'b0010;
        #1;
        total++; if (bus.wb_valid !== 1'b1 || bus.unit_ack !== 4'b0000) begin bad++; $display("FAIL rm_pre got=%b/%b want=1/0000", bus.wb_valid, bus.unit_ack); end
        rst = 1'b0;
        #1;
        total++; if (bus.wb_valid !== 1'b0 || bus.wb_data !== 34'h0) begin bad++; $display("FAIL rm_drop got=%b/%h want=0/0", bus.wb_valid, bus.wb_data); end
        set_unit(0, 34'h2_FFFF0000, 3'd7);
        bus.unit_done = 4'b0011;
        bus.wb_ready  = 1'b1;
        #1;
        total++; if (bus.unit_ack !== 4'b0000) begin bad++; $display("FAIL rm_ack_low got=%b want=0000", bus.unit_ack); end
        rst = 1'b1;
        #1;
        total++; if (bus.unit_ack !== 4'b0001) begin bad++; $display("FAIL rm_ptr0 got=%b want=0001", bus.unit_ack); end
        cyc();
        bus.unit_done = 4'b0010;
        total++; if (bus.wb_data !== 34'h2_FFFF0000 || bus.wb_grant_idx !== 2'd0) begin bad++; $display("FAIL rm_data got=%h/%0d want=2ffff0000/0", bus.wb_data, bus.wb_grant_idx); end
        #1;
        total++; if (bus.unit_ack !== 4'b0010) begin bad++; $display("FAIL rm_next_ack got=%b want=0010", bus.unit_ack); end
        cyc();
        bus.unit_done = 4'b0000;
    endtask

    task automatic test_idle_drain();
        #1;
        total++; if (bus.wb_valid !== 1'b1 || bus.unit_ack !== 4'b0000) begin bad++; $display("FAIL drain_pre got=%b/%b want=1/0000", bus.wb_valid, bus.unit_ack); end
        cyc();
        total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b want=0", bus.wb_valid); end
        total++; if (bus.wb_data !== 34'h1_EEEE0000) begin bad++; $display("FAIL drain_data got=%h want=1eeee0000", bus.wb_data); end
    endtask

    task automatic test_random();
        logic [DW-1:0] u_rd   [N];
        logic [IW-1:0] u_id   [N];
        logic [N-1:0]  u_done;
        int            wait_cnt [N];
        logic          m_valid;
        logic [DW-1:0] m_data;
        logic [IW-1:0] m_id;
        int            m_idx;
        int            m_ptr;
        logic          ready;
        logic          load;
        int            p;
        logic [N-1:0]  want;
        logic [63:0]   rnd;

        bus.unit_done = '0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        m_valid = 1'b0; m_data = '0; m_id = '0; m_idx = 0; m_ptr = 0;
        u_done = '0;
        for (int i = 0; i < N; i++) begin
            u_rd[i] = '0; u_id[i] = '0; wait_cnt[i] = 0;
        end
        cyc();
        for (int c = 0; c < 500; c++) begin
            total++; if (bus.wb_valid !== m_valid) begin bad++; $display("FAIL rnd_valid c%0d got=%b want=%b", c, bus.wb_valid, m_valid); end
            total++; if (bus.wb_data !== m_data || bus.wb_id !== m_id) begin bad++; $display("FAIL rnd_payload c%0d got=%h/%0d want=%h/%0d", c, bus.wb_data, bus.wb_id, m_data, m_id); end
            total++; if (bus.wb_grant_idx !== 2'(m_idx)) begin bad++; $display("FAIL rnd_idx c%0d got=%0d want=%0d", c, bus.wb_grant_idx, m_idx); end
            for (int i = 0; i < N; i++) begin
                if (!u_done[i] && ($urandom_range(0, 1) == 1)) begin
                    rnd = {$urandom, $urandom};
                    u_rd[i]   = rnd[DW-1:0];
                    u_id[i]   = IW'($urandom);
                    u_done[i] = 1'b1;
                end
                set_unit(i, u_rd[i], u_id[i]);
            end
            ready = ($urandom_range(0, 3) != 0);
            bus.unit_done = u_done;
            bus.wb_ready  = ready;
            #1;
            load = !m_valid || ready;
            p    = load ? ref_pick(u_done, m_ptr) : -1;
            want = (p >= 0) ? (N'(1) << p) : '0;
            total++; if (bus.unit_ack !== want) begin bad++; $display("FAIL rnd_ack c%0d got=%b want=%b", c, bus.unit_ack, want); end
            for (int i = 0; i < N; i++) begin
                if (load && u_done[i]) wait_cnt[i]++;
            end
            if (p >= 0) begin
                total++; if (wait_cnt[p] > N) begin bad++; $display("FAIL rnd_fair unit%0d got=%0d want<=%0d", p, wait_cnt[p], N); end
                wait_cnt[p] = 0;
                m_valid = 1'b1; m_data = u_rd[p]; m_id = u_id[p]; m_idx = p; m_ptr = (p + 1) % N;
                u_done[p] = 1'b0;
            end else if (load) begin
                m_valid = 1'b0;
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_ptr_wrap();
        test_reset_mid();
        test_idle_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
